// File: rtl/stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_ctrl_pkg
// Description : Shared definitions for the CPU stage sequencer: stage codes,
//               memory-select codes and the stage-enable one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_ctrl_pkg;

    localparam int STAGE_W = 3;

    // Stage codes as seen on the stage output
    typedef enum logic [STAGE_W-1:0] {
        STG_IDLE   = 3'd0,
        STG_FETCH  = 3'd1,
        STG_DECODE = 3'd2,
        STG_EXEC   = 3'd3,
        STG_WB     = 3'd4,
        STG_HALT   = 3'd5
    } stage_t;

    // Memory port address select
    localparam logic MEMSEL_INS = 1'b0;  // instruction address (pc)
    localparam logic MEMSEL_DAT = 1'b1;  // data address

    // One-hot enable for the four working stages (bit0=FETCH .. bit3=WB).
    // IDLE and HALT have no enable.
    function automatic logic [3:0] stage_en_of(input stage_t s);
        logic [3:0] en;
        en = 4'b0000;
        case (s)
            STG_FETCH:  en = 4'b0001;
            STG_DECODE: en = 4'b0010;
            STG_EXEC:   en = 4'b0100;
            STG_WB:     en = 4'b1000;
            default:    en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_ctrl_step_sync.sv
`default_nettype none
// ============================================================================
// Module      : stage_ctrl_step_sync
// Description : Synchronizer for the asynchronous step button followed by a
//               rising-edge detector. Emits a single-cycle pulse per press.
// Ports       : clk      - system clock
//               rst_n    - asynchronous reset, active-low
//               async_in - raw button level, asynchronous to clk
//               pulse    - one-cycle pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ctrl_step_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_FF-1:0] sync_q;
    logic [SYNC_FF-1:0] sync_d;
    logic               prev_q;
    logic               prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_FF-2:0], async_in};
        prev_d = sync_q[SYNC_FF-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Pulse is high for the one cycle the synchronized level is new
    assign pulse = sync_q[SYNC_FF-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stage_ctrl
// Description : Stage sequencer for the multi-cycle CPU datapath
//               (FETCH->DECODE->EXEC->WB). Runs freely in auto mode or one
//               stage per button press in manual mode, owns the shared memory
//               request/ack handshake and stops in HALT on a decoded halt or a
//               memory timeout.
// Ports       : clk, rst_n         - clock, async active-low reset
//               is_auto            - 1 = free-run, 0 = manual step
//               next_stage         - raw step button (asynchronous)
//               halt_req, mem_op   - decode results, sampled in DECODE
//               mem_ack            - memory completed the current request
//               stage              - current stage code
//               stage_en           - one-hot pulse on first cycle of a stage
//               mem_req, mem_sel   - memory request level and address select
//               halted, timeout    - in HALT / HALT entered via timeout
//               instr_count        - retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int SYNC_FF  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_auto,
    input  logic        next_stage,
    input  logic        halt_req,
    input  logic        mem_op,
    input  logic        mem_ack,
    output logic [2:0]  stage,
    output logic [3:0]  stage_en,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        halted,
    output logic        timeout,
    output logic [15:0] instr_count
);

    localparam logic [7:0] c_wait_max = 8'(WAIT_MAX);

    stage_t      stage_q,       stage_d;
    logic [3:0]  stage_en_q,    stage_en_d;
    logic        mem_req_q,     mem_req_d;
    logic        mem_sel_q,     mem_sel_d;
    logic        mem_op_q,      mem_op_d;
    logic        ack_seen_q,    ack_seen_d;
    logic        step_pend_q,   step_pend_d;
    logic        timeout_q,     timeout_d;
    logic [7:0]  wait_cnt_q,    wait_cnt_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic        w_step_pulse;
    logic        w_adv;
    logic        w_take;
    logic        w_tmo_hit;
    logic [7:0]  w_wait_inc;

    stage_ctrl_step_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_step_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (next_stage),
        .pulse    (w_step_pulse)
    );

    assign w_adv      = is_auto | step_pend_q;
    assign w_wait_inc = wait_cnt_q + 8'd1;
    // This cycle would be the WAIT_MAX-th consecutive unacknowledged one
    assign w_tmo_hit  = mem_req_q & ~mem_ack & (w_wait_inc == c_wait_max);

    // Next-stage decision
    always_comb begin
        stage_d = stage_q;
        case (stage_q)
            STG_IDLE:   if (w_adv) stage_d = STG_FETCH;
            STG_FETCH:  if (w_adv && ack_seen_q) stage_d = STG_DECODE;
            STG_DECODE: if (w_adv) stage_d = halt_req ? STG_HALT : STG_EXEC;
            STG_EXEC:   if (w_adv && (!mem_op_q || ack_seen_q)) stage_d = STG_WB;
            STG_WB:     if (w_adv) stage_d = STG_FETCH;
            STG_HALT:   stage_d = STG_HALT;
            default:    stage_d = STG_IDLE;
        endcase
        // A memory timeout wins over any advance in the same cycle
        if (w_tmo_hit) stage_d = STG_HALT;
    end

    assign w_take = (stage_d != stage_q);

    // Handshake, step and counter bookkeeping
    always_comb begin
        stage_en_d    = w_take ? stage_en_of(stage_d) : 4'b0000;
        mem_op_d      = (stage_q == STG_DECODE) ? mem_op : mem_op_q;
        timeout_d     = timeout_q | w_tmo_hit;
        instr_count_d = (w_take && stage_q == STG_WB) ? instr_count_q + 16'd1 : instr_count_q;

        // A pending step is consumed only by an actual transition
        step_pend_d = w_take ? 1'b0 : (step_pend_q | (w_step_pulse & ~is_auto));

        ack_seen_d = ack_seen_q;
        if (w_take) begin
            ack_seen_d = 1'b0;
        end else if (mem_req_q && mem_ack) begin
            ack_seen_d = 1'b1;
        end

        mem_req_d = mem_req_q;
        mem_sel_d = mem_sel_q;
        if (mem_req_q && mem_ack) mem_req_d = 1'b0;
        if (w_take && stage_d == STG_FETCH) begin
            mem_req_d = 1'b1;
            mem_sel_d = MEMSEL_INS;
        end else if (w_take && stage_d == STG_EXEC && mem_op) begin
            // mem_op is being latched on this same edge
            mem_req_d = 1'b1;
            mem_sel_d = MEMSEL_DAT;
        end
        if (w_tmo_hit) mem_req_d = 1'b0;

        wait_cnt_d = (mem_req_q && !mem_ack && !w_tmo_hit) ? w_wait_inc : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= STG_IDLE;
            stage_en_q    <= 4'b0000;
            mem_req_q     <= 1'b0;
            mem_sel_q     <= MEMSEL_INS;
            mem_op_q      <= 1'b0;
            ack_seen_q    <= 1'b0;
            step_pend_q   <= 1'b0;
            timeout_q     <= 1'b0;
            wait_cnt_q    <= 8'd0;
            instr_count_q <= 16'd0;
        end else begin
            stage_q       <= stage_d;
            stage_en_q    <= stage_en_d;
            mem_req_q     <= mem_req_d;
            mem_sel_q     <= mem_sel_d;
            mem_op_q      <= mem_op_d;
            ack_seen_q    <= ack_seen_d;
            step_pend_q   <= step_pend_d;
            timeout_q     <= timeout_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign stage       = stage_q;
    assign stage_en    = stage_en_q;
    assign mem_req     = mem_req_q;
    assign mem_sel     = mem_sel_q;
    assign halted      = (stage_q == STG_HALT);
    assign timeout     = timeout_q;
    assign instr_count = instr_count_q;

endmodule
`default_nettype wire
